uart_rx_fsm: RTL and testbench

UART receive controller: the receive-side counterpart of the UART transmit path. It oversamples a pre-synchronised serial line, detects the start bit and rejects start glitches. It recovers DATA_WIDTH bits LSB-first, checks optional parity and the stop bit, and presents a parallel byte with a one-cycle valid strobe. It contains the FSM, the edge/bit counters, the 3-sample majority sampler, the deserialiser, and the parity and stop checkers.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_fsm.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: serial input, frame configuration and the
// received-byte/status strobes.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: start-glitch rejection, 3-sample majority voting,
// LSB-first deserialisation, optional parity and stop checking with one-cycle strobes.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic    clk,
  input  logic    rstn,
  uart_rx_if.slave bus
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic [1:0]            samp_q, samp_d;
  logic                  bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  busy_q, busy_d;

  logic [PRESCALE_W-1:0] prescale_sel;
  logic [PRESCALE_W-1:0] half;
  logic                  at_last;

  // Unsupported ratios fall back to 8x so the counters always wrap sensibly.
  always_comb begin
    prescale_sel = PRESCALE_W'(8);
    case (bus.Prescale)
      PRESCALE_W'(8), PRESCALE_W'(16), PRESCALE_W'(32): prescale_sel = bus.Prescale;
      default: prescale_sel = PRESCALE_W'(8);
    endcase
  end

  assign half    = prescale_q >> 1;
  assign at_last = (edge_cnt_q == prescale_q - PRESCALE_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      prescale_q <= PRESCALE_W'(8);
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      samp_q     <= '0;
      bit_q      <= 1'b0;
      shift_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      prescale_q <= prescale_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    prescale_d = prescale_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    // Three samples around mid-bit; the vote is registered on the third one.
    if (state_q != IDLE) begin
      edge_cnt_d = at_last ? '0 : edge_cnt_q + PRESCALE_W'(1);
      if (edge_cnt_q == half - PRESCALE_W'(2)) samp_d[0] = bus.RX_IN;
      if (edge_cnt_q == half - PRESCALE_W'(1)) samp_d[1] = bus.RX_IN;
      if (edge_cnt_q == half)
        bit_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & bus.RX_IN) | (samp_q[1] & bus.RX_IN);
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (!bus.RX_IN) begin
          state_d    = START;
          edge_cnt_d = PRESCALE_W'(1);
          prescale_d = prescale_sel;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          par_bad_d  = 1'b0;
        end
      end
      START: begin
        if (at_last) begin
          state_d   = bit_q ? IDLE : DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (at_last) begin
          shift_d   = {bit_q, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1))
            state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_last) begin
          par_bad_d = bit_q ^ (^shift_q) ^ par_typ_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (at_last) begin
          state_d = IDLE;
          se_d    = ~bit_q;
          pe_d    = par_bad_q;
          dv_d    = bit_q & ~par_bad_q;
          if (bit_q && !par_bad_q) p_data_d = shift_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: a frame-level model queues the expected outcome and
// arrival cycle of each frame; a negedge monitor pops and compares on every strobe.
module tb_uart_rx_fsm;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            busy_run = 0;
  int            last_busy_len = -1;
  logic [DW-1:0] last_good = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rstn && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        check("data_valid", int'(bus.data_valid), int'(e.dv));
        check("par_err", int'(bus.par_err), int'(e.pe));
        check("stp_err", int'(bus.stp_err), int'(e.se));
        check("P_DATA", int'(bus.P_DATA), int'(e.data));
        check("strobe_cycle", cyc, e.cyc);
        $display("[TB] frame: dv=%0d pe=%0d se=%0d P_DATA=0x%02h cyc=%0d", bus.data_valid,
                 bus.par_err, bus.stp_err, bus.P_DATA, cyc);
      end
    end
    if (bus.busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
  end

  task automatic drive_bit(input logic b, input int p);
    bus.RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model: outcome and arrival time follow from the frame contents alone.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input int pc, input logic bad_par, input logic stop);
    int   p;
    logic ok;
    exp_t x;
    p  = (pc == 8 || pc == 16 || pc == 32) ? pc : 8;
    ok = !(pen && bad_par) && stop;
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    bus.Prescale = PW'(pc);
    if (ok) last_good = d;
    x.dv   = ok;
    x.pe   = pen & bad_par;
    x.se   = ~stop;
    x.data = last_good;
    x.cyc  = cyc + (DW + 2 + int'(pen)) * p;
    q.push_back(x);
    drive_bit(1'b0, p);
    for (int i = 0; i < DW; i++) drive_bit(d[i], p);
    if (pen) drive_bit((^d) ^ ptyp ^ bad_par, p);
    drive_bit(stop, p);
  endtask

  initial begin
    int pc_tbl[8] = '{8, 16, 32, 8, 16, 32, 5, 12};
    rstn         = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.Prescale = PW'(8);
    repeat (3) @(negedge clk);
    check("reset_P_DATA", int'(bus.P_DATA), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_strobes", int'({bus.data_valid, bus.par_err, bus.stp_err}), 0);
    rstn = 1'b1;
    idle(4);

    // 1: even parity, good frame
    send_frame(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b1);
    idle(3);
    check("busy_len_frame", last_busy_len, 11 * 8 - 1);
    // 2: odd parity, wrong parity bit
    send_frame(8'h3C, 1'b1, 1'b1, 8, 1'b1, 1'b1);
    idle(5);
    // 3: P=16, no parity, stop low
    send_frame(8'h5A, 1'b0, 1'b0, 16, 1'b0, 1'b0);
    idle(5);
    // 4: start glitch
    bus.Prescale = PW'(8);
    drive_bit(1'b0, 2);
    idle(12);
    check("glitch_busy_len", last_busy_len, 7);
    check("glitch_busy_now", int'(bus.busy), 0);
    // 5: back-to-back at P=32
    send_frame(8'h00, 1'b0, 1'b0, 32, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 32, 1'b0, 1'b1);
    idle(5);
    // 6: reset mid-DATA, then the same frame again
    bus.PAR_EN   = 1'b0;
    bus.Prescale = PW'(8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 3);
    rstn = 1'b0;
    #1;
    check("midreset_P_DATA", int'(bus.P_DATA), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_strobes", int'({bus.data_valid, bus.par_err, bus.stp_err}), 0);
    @(negedge clk);
    last_good = '0;
    bus.RX_IN = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b0, 1'b0, 8, 1'b0, 1'b1);
    idle(5);
    // Line stuck low: two frames of zeros with stop errors, no gap
    send_frame(8'h00, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    idle(5);

    for (int n = 0; n < 30; n++) begin
      send_frame(DW'($urandom), 1'($urandom), 1'($urandom), pc_tbl[$urandom_range(0, 7)],
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
